// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between the instruction-fetch and data requesters.
// An in-order owner FIFO sends each response back to the requester that issued it.
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4,
    localparam int CW             = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          inst_req_i,
    input  logic          inst_wr_i,
    input  logic [1:0]    inst_size_i,
    input  logic [3:0]    inst_wstrb_i,
    input  logic [31:0]   inst_addr_i,
    input  logic [31:0]   inst_wdata_i,
    output logic          inst_addr_ok_o,
    output logic          inst_data_ok_o,
    output logic [31:0]   inst_rdata_o,
    input  logic          data_req_i,
    input  logic          data_wr_i,
    input  logic [1:0]    data_size_i,
    input  logic [3:0]    data_wstrb_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_addr_ok_o,
    output logic          data_data_ok_o,
    output logic [31:0]   data_rdata_o,
    output logic          mem_req_o,
    output logic          mem_wr_o,
    output logic [1:0]    mem_size_o,
    output logic [3:0]    mem_wstrb_o,
    output logic [31:0]   mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_addr_ok_i,
    input  logic          mem_data_ok_i,
    input  logic [31:0]   mem_rdata_i,
    output logic [CW-1:0] outstanding_o,
    output logic          resp_err_o
);

    localparam int PW = CW - 1;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       lock_valid_q, lock_valid_d;
    owner_e                     lock_owner_q, lock_owner_d;
    logic [3:0]                 starve_q, starve_d;
    logic                       resp_err_q, resp_err_d;

    logic   grant_valid;
    owner_e grant_owner;
    logic   sel_data;
    logic   accept;
    logic   pop;
    logic   head;

    // A stalled request keeps its owner so the memory sees a stable payload.
    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OWNER_INST;
        if (lock_valid_q) begin
            grant_valid = 1'b1;
            grant_owner = lock_owner_q;
        end else if (count_q != CW'(MAX_OUTSTANDING)) begin
            if (starve_q >= 4'(STARVE_LIMIT) && inst_req_i) begin
                grant_valid = 1'b1;
                grant_owner = OWNER_INST;
            end else if (data_req_i) begin
                grant_valid = 1'b1;
                grant_owner = OWNER_DATA;
            end else if (inst_req_i) begin
                grant_valid = 1'b1;
                grant_owner = OWNER_INST;
            end
        end
    end

    assign sel_data = (grant_owner == OWNER_DATA);
    assign accept   = grant_valid & mem_addr_ok_i;
    assign pop      = mem_data_ok_i & (count_q != '0);
    assign head     = fifo_q[rptr_q];

    assign mem_req_o   = grant_valid;
    assign mem_wr_o    = sel_data ? data_wr_i    : inst_wr_i;
    assign mem_size_o  = sel_data ? data_size_i  : inst_size_i;
    assign mem_wstrb_o = sel_data ? data_wstrb_i : inst_wstrb_i;
    assign mem_addr_o  = sel_data ? data_addr_i  : inst_addr_i;
    assign mem_wdata_o = sel_data ? data_wdata_i : inst_wdata_i;

    assign inst_addr_ok_o = accept & ~sel_data;
    assign data_addr_ok_o = accept & sel_data;
    assign inst_data_ok_o = pop & ~head;
    assign data_data_ok_o = pop & head;
    assign inst_rdata_o   = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign outstanding_o  = count_q;
    assign resp_err_o     = resp_err_q;

    always_comb begin
        fifo_d       = fifo_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        starve_d     = 4'd0;
        resp_err_d   = resp_err_q | (mem_data_ok_i & (count_q == '0));

        if (accept) begin
            fifo_d[wptr_q] = sel_data;
            wptr_d         = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (accept) begin
            lock_valid_d = 1'b0;
        end else if (grant_valid) begin
            lock_valid_d = 1'b1;
            lock_owner_d = grant_owner;
        end

        // Saturating count of cycles that fetch has been asking without success.
        if (inst_req_i && !inst_addr_ok_o) begin
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fifo_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= OWNER_INST;
            starve_q     <= 4'd0;
            resp_err_q   <= 1'b0;
        end else begin
            fifo_q       <= fifo_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            starve_q     <= starve_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Arbitrates the CPU's instruction-fetch and data-access request ports onto one shared SRAM-like memory port, sitting between mycpu_top's IF/EX/MEM stages and the single memory bridge. Requests use the req/addr_ok/data_ok split-transaction handshake. The block tracks the owner of every accepted transaction in an in-order FIFO so that each response returns to the requester that issued it. It prefers data requests, with a starvation guard for fetch.

## Interface
- MAX_OUTSTANDING, 2: maximum accepted but unanswered transactions; power of 2, range 2..8.
- STARVE_LIMIT, 4: consecutive cycles of denied fetch before fetch is forced to win; range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req / data_req  in  1  request valid. Each requester holds it and its payload stable until its addr_ok.
- inst_wr / data_wr  in  1  1 = write.
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word.
- inst_wstrb / data_wstrb  in  4  byte enables.
- inst_addr / data_addr  in  32  address.
- inst_wdata / data_wdata  in  32  write data.
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle.
- inst_data_ok / data_data_ok  out  1  response for this requester this cycle.
- inst_rdata / data_rdata  out  32  both driven from mem_rdata.
- mem_req, mem_wr, mem_size[2], mem_wstrb[4], mem_addr[32], mem_wdata[32]  out  request to memory, muxed from the granted requester.
- mem_addr_ok, mem_data_ok  in  1  memory handshakes.
- mem_rdata  in  32  read data.
- outstanding  out  log2(MAX_OUTSTANDING)+1  live transaction count.
- resp_err  out  1  sticky flag: mem_data_ok arrived with the FIFO empty.

## Operation
- **State**
  - owner FIFO: MAX_OUTSTANDING entries of 1 bit each (0 = inst, 1 = data), with read/write pointers and count.
  - lock_valid, lock_owner.
  - starve_cnt: 4 bits.
  - resp_err.
- **Grant selection** (combinational; used only when lock_valid = 0):
  - count == MAX_OUTSTANDING: no grant.
  - starve_cnt >= STARVE_LIMIT and inst_req: grant inst.
  - otherwise, data_req: grant data.
  - otherwise, inst_req: grant inst.
  - otherwise: no grant.
- **Lock**
  - When lock_valid = 1, the grant is lock_owner regardless of priority or count.
  - When mem_req = 1 and mem_addr_ok = 0, set lock_valid and lock_owner = current grant. This keeps mem_addr and payload stable across stalls.
  - Clear lock_valid on mem_addr_ok.
- **Memory request**
  - mem_req = 1 when there is a grant. mem_* payload is the granted requester's payload.
  - Payload value is don't-care when mem_req = 0, but the mux defaults to inst.
- **Accept**
  - Accept = mem_req & mem_addr_ok.
  - The granted requester's addr_ok = mem_addr_ok & grant. The other requester's addr_ok = 0.
  - On accept, push the grant owner into the FIFO.
- **Response**
  - On mem_data_ok with count > 0, pop the head. inst_data_ok = head==0; data_data_ok = head==1.
  - On mem_data_ok with count == 0, both data_ok outputs are 0 and resp_err is set. resp_err clears only on reset.
- **Counts and pointers**
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUTSTANDING.
- **Starvation counter** (saturating at 15):
  - starve_cnt increments when inst_req = 1 and inst is not accepted this cycle.
  - Resets to 0 when inst is accepted or inst_req = 0.
- **Full FIFO**
  - A pending lock still asserts mem_req, because the lock was taken when count < MAX.
  - This cannot overflow: the lock only exists when count < MAX at lock time, and count does not grow until this accept.

## Timing
- **Reset values** (async assert, sync release):
  - FIFO empty, outstanding = 0.
  - lock_valid = 0, starve_cnt = 0, resp_err = 0.
  - With inputs idle: mem_req = 0, and all addr_ok/data_ok = 0.
- **Latency**
  - addr_ok, data_ok, rdata and mem_* are combinational, with zero added cycles.
  - Owner and count updates are visible the cycle after accept or response.
- **Same-cycle response**
  - A transaction accepted in cycle N may be answered no earlier than N+1, since its FIFO entry is written at the N edge.
  - mem_data_ok in N refers only to entries present before N.
- **Reset mid-transaction**
  - All tracking is dropped.
  - The memory side must be reset by the same signal; late responses after reset set resp_err.

## Test plan
- **Priority and lock**
  - Stimulus: both requests asserted in the same cycle, mem_addr_ok = 1.
  - Required: data granted, data_addr_ok = 1, inst_addr_ok = 0, outstanding 0 → 1.
  - Stimulus: mem_addr_ok held 0 for 3 cycles with data pending, then inst_req rises.
  - Required: mem_addr stays data_addr throughout; inst is not granted until the data accept.
- **Response routing**
  - Stimulus: accept inst (addr 0x1c000000), then data (addr 0x1000); return mem_data_ok with rdata 0x11111111, then 0x22222222.
  - Required: inst_data_ok with 0x11111111 first, then data_data_ok with 0x22222222; outstanding ends at 0.
- **Full FIFO**
  - Stimulus: MAX_OUTSTANDING = 2; accept 2 transactions with no response.
  - Required: third request sees mem_req = 0.
  - Stimulus: mem_data_ok and a new request in the same cycle.
  - Required: accept proceeds next cycle; outstanding stays at 2.
- **Starvation**
  - Stimulus: data_req and inst_req held continuously, mem_addr_ok = 1, STARVE_LIMIT = 4.
  - Required: 4 consecutive data accepts, then one inst accept; starve_cnt returns to 0.
- **Spurious response**
  - Stimulus: mem_data_ok with the FIFO empty.
  - Required: both data_ok = 0, resp_err = 1 and held.
  - Stimulus: assert reset mid-stall.
  - Required: resp_err = 0, outstanding = 0, lock_valid = 0 immediately.
